// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and the
// baud divisor helper used by both the transmitter and the future receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int unsigned DATA_BITS = 8;

   // Clock cycles per line bit, truncated.
   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 while enabled and pulses o_bit_done on
// the last cycle of each bit period. i_clr holds the count at zero.
module uart_baud_gen #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_bit_done
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_count;

   // Cycle counter, wrapping at the end of each bit period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr || !i_en) begin
         r_count <= '0;
      end else if (r_count == LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_bit_done = i_en && !i_clr && (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends
// start bit, 8 data bits LSB first, optional odd parity, and stop bit.
// BAUD_DIV = CLK_FREQUENCY/BAUD_RATE must be at least 2.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY = 100_000_000,
   parameter int unsigned BAUD_RATE     = 19_200,
   parameter bit          PARITY_EN     = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] din,
   input  logic                 send_valid,
   output logic                 send_ready,
   output logic                 tx_out,
   output logic                 tx_busy
);

   localparam int unsigned BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);

   tx_state_t            r_state, w_state_next;
   logic [DATA_BITS-1:0] r_shift, w_shift_next;
   logic [2:0]           r_bit_idx, w_bit_idx_next;
   logic                 r_parity, w_parity_next;
   logic                 r_tx, w_tx_next;
   logic                 w_bit_done;
   logic                 w_idle;

   assign w_idle = (r_state == IDLE);

   uart_baud_gen #(
      .DIV(BAUD_DIV)
   ) u_baud_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (1'b1),
      .i_clr     (w_idle),
      .o_bit_done(w_bit_done)
   );

   // State, datapath and line registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_idx <= w_bit_idx_next;
         r_parity  <= w_parity_next;
         r_tx      <= w_tx_next;
      end
   end

   // Next-state logic; the line level is derived from the state being
   // entered so the registered tx_out lines up with r_state.
   always_comb begin
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_bit_idx_next = r_bit_idx;
      w_parity_next  = r_parity;
      w_tx_next      = 1'b1;

      case (r_state)
         IDLE: begin
            if (send_valid) begin
               w_state_next  = START;
               w_shift_next  = din;
               w_parity_next = ~^din;
            end
         end
         START: begin
            if (w_bit_done) begin
               w_state_next   = DATA;
               w_bit_idx_next = '0;
            end
         end
         DATA: begin
            if (w_bit_done) begin
               w_shift_next = r_shift >> 1;
               if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                  w_bit_idx_next = '0;
                  w_state_next   = PARITY_EN ? PARITY : STOP;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end
         end
         PARITY: begin
            if (w_bit_done) begin
               w_state_next = STOP;
            end
         end
         STOP: begin
            if (w_bit_done) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      case (w_state_next)
         IDLE:    w_tx_next = 1'b1;
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = w_shift_next[0];
         PARITY:  w_tx_next = w_parity_next;
         STOP:    w_tx_next = 1'b1;
         default: w_tx_next = 1'b1;
      endcase
   end

   assign send_ready = w_idle;
   assign tx_busy    = !w_idle;
   assign tx_out     = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with BAUD_DIV = 10: a scoreboard queue of
// expected frames is filled by the stimulus and drained by a line monitor.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = '0;
   logic       send_valid = 1'b0;
   logic       send_ready, tx_out, tx_busy;

   logic [7:0] np_din = '0;
   logic       np_valid = 1'b0;
   logic       np_ready, np_tx, np_busy;

   int checks = 0;
   int failures = 0;

   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx #(
      .CLK_FREQUENCY(100),
      .BAUD_RATE    (10),
      .PARITY_EN    (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .send_valid(send_valid),
      .send_ready(send_ready),
      .tx_out    (tx_out),
      .tx_busy   (tx_busy)
   );

   uart_tx #(
      .CLK_FREQUENCY(100),
      .BAUD_RATE    (10),
      .PARITY_EN    (1'b0)
   ) dut_np (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (np_din),
      .send_valid(np_valid),
      .send_ready(np_ready),
      .tx_out    (np_tx),
      .tx_busy   (np_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   // Line monitor: on a start bit, pop the expected frame and check every
   // bit at mid-bit. A reset abandons the frame in flight.
   initial begin
      bit          active = 1'b0;
      bit          have_exp = 1'b0;
      int          c = 0;
      logic [10:0] fr = '1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
            continue;
         end
         if (!active) begin
            if (tx_out == 1'b0) begin
               active = 1'b1;
               c = 0;
               if (exp_q.size() == 0) begin
                  have_exp = 1'b0;
                  checks++;
                  failures++;
                  $display("FAIL unexpected_frame: start bit with empty scoreboard at %0t", $time);
               end else begin
                  have_exp = 1'b1;
                  fr = exp_q.pop_front();
               end
            end
         end else begin
            c++;
         end
         if (active) begin
            if (have_exp && (c % 10 == 5))
               chk($sformatf("frame_bit%0d", c / 10), {31'd0, tx_out}, {31'd0, fr[c / 10]});
            if (c == 109) active = 1'b0;
         end
      end
   end

   task automatic wait_ready();
      int k = 0;
      while (!send_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!send_ready) timeout_fail("wait_ready");
   endtask

   // One frame with the expected parity bit given by hand; optionally pulse
   // a rejected send of 8'hFF at busy cycle pulse_at.
   task automatic send_frame(input logic [7:0] b, input logic par, input int pulse_at);
      int n = 0;
      int rdy_hi = 0;
      wait_ready();
      exp_q.push_back({1'b1, par, b, 1'b0});
      din = b;
      send_valid = 1'b1;
      @(negedge clk);
      send_valid = 1'b0;
      din = ~b;
      chk("start_latency", {31'd0, tx_out}, 32'd0);
      chk("busy_rise", {31'd0, tx_busy}, 32'd1);
      while (tx_busy && n < 300) begin
         n++;
         if (send_ready) rdy_hi++;
         if (n == pulse_at) begin
            din = 8'hFF;
            send_valid = 1'b1;
         end else begin
            send_valid = 1'b0;
         end
         @(negedge clk);
      end
      send_valid = 1'b0;
      chk("busy_len", n, 32'd110);
      chk("ready_while_busy", rdy_hi, 32'd0);
      chk("ready_at_end", {31'd0, send_ready}, 32'd1);
   endtask

   initial begin
      int lows;
      int n;
      int gap;

      // reset
      repeat (3) @(negedge clk);
      chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
      chk("rst_ready", {31'd0, send_ready}, 32'd1);
      chk("rst_busy", {31'd0, tx_busy}, 32'd0);
      rst_n = 1'b1;
      lows = 0;
      repeat (50) begin
         @(negedge clk);
         if (!tx_out) lows++;
      end
      chk("idle_line_low_cycles", lows, 32'd0);

      // single frames and parity variants
      send_frame(8'hA5, 1'b1, 0);
      send_frame(8'h07, 1'b0, 0);
      send_frame(8'h00, 1'b1, 0);

      // rejected send while busy
      send_frame(8'h3C, 1'b1, 40);

      // back-to-back with send_valid held
      wait_ready();
      exp_q.push_back({1'b1, 1'b1, 8'h55, 1'b0});
      exp_q.push_back({1'b1, 1'b1, 8'hAA, 1'b0});
      din = 8'h55;
      send_valid = 1'b1;
      @(negedge clk);
      chk("b2b_first_accept", {31'd0, tx_busy}, 32'd1);
      din = 8'hAA;
      n = 0;
      while (tx_busy && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_first_len", n, 32'd110);
      gap = 0;
      while (!tx_busy && gap < 20) begin
         gap++;
         @(negedge clk);
      end
      chk("b2b_gap", gap, 32'd1);
      chk("b2b_second_start", {31'd0, tx_out}, 32'd0);
      send_valid = 1'b0;
      din = 8'h00;
      n = 0;
      while (tx_busy && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_second_len", n, 32'd110);

      // parity disabled: 8'h00 is 100 cycles, stop bit right after data
      np_din = 8'h00;
      np_valid = 1'b1;
      @(negedge clk);
      np_valid = 1'b0;
      np_din = 8'hFF;
      chk("np_start_latency", {31'd0, np_tx}, 32'd0);
      n = 0;
      while (np_busy && n < 300) begin
         if (n % 10 == 5 && n < 100)
            chk($sformatf("np_bit%0d", n / 10), {31'd0, np_tx}, (n / 10 == 9) ? 32'd1 : 32'd0);
         n++;
         @(negedge clk);
      end
      chk("np_busy_len", n, 32'd100);
      chk("np_idle_high", {31'd0, np_tx}, 32'd1);

      // reset in the middle of a frame
      wait_ready();
      exp_q.push_back({1'b1, 1'b1, 8'h00, 1'b0});
      din = 8'h00;
      send_valid = 1'b1;
      @(negedge clk);
      send_valid = 1'b0;
      repeat (54) @(negedge clk);
      chk("pre_reset_low", {31'd0, tx_out}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tx_out", {31'd0, tx_out}, 32'd1);
      chk("async_rst_ready", {31'd0, send_ready}, 32'd1);
      chk("async_rst_busy", {31'd0, tx_busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, send_ready}, 32'd1);
      send_frame(8'h81, 1'b1, 0);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
